twiddle_gen_ctrl: RTL

TWIDDLE_GEN_CTRL -- requirements
Module: twiddle_gen_ctrl

---
 rtl/twiddle_gen_ctrl_pkg.sv | 14 +
 rtl/barrett_reduction.sv | 42 ++++
 rtl/define.svh | 5 +
 rtl/twiddle_gen_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/twiddle_gen_ctrl_pkg.sv
// Shared types and defaults for the twiddle-table generator.
package twiddle_gen_ctrl_pkg;

  localparam int unsigned DefAddrWidth = 10;

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StMul,
    StCap,
    StFin
  } state_e;

endpackage

// File: rtl/barrett_reduction.sv
// Modular multiplier: result = (a * b) mod modulus, registered (1-cycle latency).
module barrett_reduction #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRECOMPUTE = 514
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned EW    = 4 * DATA_WIDTH + 2;
  localparam int unsigned Shift = 2 * DATA_WIDTH + 1;

  logic [PW-1:0] prod, quot, rem0, rem1, rem2, mod_ext;
  logic [EW-1:0] est;

  // PRECOMPUTE ~ 2^(2W+1)/q, so the quotient estimate is short by at most two.
  always_comb begin
    mod_ext = PW'(modulus);
    prod    = PW'(a) * PW'(b);
    est     = EW'(prod) * EW'(PRECOMPUTE);
    quot    = PW'(est >> Shift);
    rem0    = prod - quot * mod_ext;
    rem1    = (rem0 >= mod_ext) ? rem0 - mod_ext : rem0;
    rem2    = (rem1 >= mod_ext) ? rem1 - mod_ext : rem1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (modulus == '0) begin
      result <= '0;
    end else begin
      result <= DATA_WIDTH'(rem2);
    end
  end

endmodule

// File: rtl/define.svh
// Project-wide width defines shared across the datapath blocks.
`ifndef DEFINE_SVH
`define DEFINE_SVH
`define D_width 8
`endif

// File: rtl/twiddle_gen_ctrl.sv
// Twiddle-table generator: writes omega^k mod q for k = 0..N-1 into a table memory.
`include "define.svh"

module twiddle_gen_ctrl
  import twiddle_gen_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `D_width,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned PRECOMPUTE = 514
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] omega,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  tw_valid,
  output logic [ADDR_WIDTH-1:0] tw_addr,
  output logic [DATA_WIDTH-1:0] tw_data,
  input  logic                  tw_ready
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] omega_q, omega_d;
  logic [DATA_WIDTH-1:0] modulus_q, modulus_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic [DATA_WIDTH-1:0] mul_a, mul_b, mul_mod, mul_result;

  barrett_reduction #(
    .DATA_WIDTH(DATA_WIDTH),
    .PRECOMPUTE(PRECOMPUTE)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .a      (mul_a),
    .b      (mul_b),
    .modulus(mul_mod),
    .result (mul_result)
  );

  always_comb begin
    state_d   = state_q;
    omega_d   = omega_q;
    modulus_d = modulus_q;
    count_d   = count_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    busy      = 1'b0;
    done      = 1'b0;
    tw_valid  = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    mul_mod   = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            omega_d   = omega;
            modulus_d = modulus;
            count_d   = count;
            acc_d     = DATA_WIDTH'(1);
            idx_d     = '0;
            state_d   = StEmit;
          end else begin
            state_d = StFin;
          end
        end
      end
      StEmit: begin
        busy     = 1'b1;
        tw_valid = 1'b1;
        if (tw_ready) begin
          state_d = (idx_q == count_q - ADDR_WIDTH'(1)) ? StFin : StMul;
        end
      end
      StMul: begin
        busy    = 1'b1;
        mul_a   = acc_q;
        mul_b   = omega_q;
        mul_mod = modulus_q;
        state_d = StCap;
      end
      StCap: begin
        busy    = 1'b1;
        acc_d   = mul_result;
        idx_d   = idx_q + ADDR_WIDTH'(1);
        state_d = StEmit;
      end
      StFin: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // acc/idx only change in StIdle and StCap, so they stay stable through a stalled write.
  assign tw_addr = idx_q;
  assign tw_data = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      omega_q   <= '0;
      modulus_q <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      omega_q   <= omega_d;
      modulus_q <= modulus_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
    end
  end

endmodule
